// File: rtl/writeback_unit_if.sv
// ----------------------------------------------------------------------------
// writeback_unit_if
//  Bundles the result/issue inputs and the register-file write port of the
//  writeback unit.
//  master : producer side (execute/memory stages, issue logic) -- drives the
//           ALU/load results and issue info, observes ready/scoreboard/write port
//  slave  : the writeback unit itself
//  Signals:
//   aluValid/aluReady/aluRd/aluData  ALU result handshake
//   memValid/memRd/memData           load result (always accepted)
//   issueValid/issueRd               destination of a newly issued instruction
//   busyMask                         pending-write scoreboard
//   rd/data/writeEnable              register-file write port
// ----------------------------------------------------------------------------
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            aluValid;
  logic            aluReady;
  logic [4:0]      aluRd;
  logic [XLEN-1:0] aluData;
  logic            memValid;
  logic [4:0]      memRd;
  logic [XLEN-1:0] memData;
  logic            issueValid;
  logic [4:0]      issueRd;
  logic [31:0]     busyMask;
  logic [4:0]      rd;
  logic [XLEN-1:0] data;
  logic            writeEnable;

  modport master (
    output aluValid, aluRd, aluData, memValid, memRd, memData, issueValid, issueRd,
    input  aluReady, busyMask, rd, data, writeEnable
  );

  modport slave (
    input  aluValid, aluRd, aluData, memValid, memRd, memData, issueValid, issueRd,
    output aluReady, busyMask, rd, data, writeEnable
  );
endinterface

// File: rtl/writeback_unit.sv
// ----------------------------------------------------------------------------
// writeback_unit
//  Arbitrates ALU and load results onto the single register-file write port
//  and tracks pending writes in a 32-bit scoreboard. Loads always win; ALU
//  results that lose arbitration wait in a small in-order FIFO. The write
//  port is registered so it is stable for a falling-edge register file.
//  Ports:
//   clk  clock, all state updates on posedge
//   rst  asynchronous active-high reset
//   wb   writeback_unit_if.slave (results in, write port + scoreboard out)
// ----------------------------------------------------------------------------
module writeback_unit #(
  parameter int XLEN           = 32,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  writeback_unit_if.slave   wb
);
  localparam int PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage (no reset needed: validity is tracked by r_count)
  logic [4:0]      r_fifo_rd   [ALU_FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [ALU_FIFO_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;

  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_data;
  logic             r_we;
  logic [31:0]      r_busy;

  logic             w_mem_commit;
  logic             w_alu_live;
  logic             w_fifo_empty;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic [CNT_W-1:0] w_count_next;
  logic [31:0]      w_busy_next;

  // Commit priority: load > FIFO head > direct ALU bypass.
  always_comb begin
    w_mem_commit = wb.memValid && (wb.memRd != 5'd0);
    w_alu_live   = wb.aluValid && (wb.aluRd != 5'd0);
    w_fifo_empty = (r_count == '0);
    w_pop        = !w_mem_commit && !w_fifo_empty;
    // Bypass only when nothing older is buffered, preserving ALU age order.
    w_bypass     = !w_mem_commit && w_fifo_empty && w_alu_live;
    w_push       = w_alu_live && !r_full && !w_bypass;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Ready comes from the registered full flag only; a same-cycle pop
  // does not make room until the next cycle.
  assign wb.aluReady    = !r_full;
  assign wb.rd          = r_rd;
  assign wb.data        = r_data;
  assign wb.writeEnable = r_we;
  assign wb.busyMask    = r_busy;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= wb.aluRd;
      r_fifo_data[r_wr_ptr] <= wb.aluData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(ALU_FIFO_DEPTH));
    end
  end

  // Write port: rd/data hold their last value when nothing commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd   <= 5'd0;
      r_data <= '0;
      r_we   <= 1'b0;
    end else if (w_mem_commit) begin
      r_rd   <= wb.memRd;
      r_data <= wb.memData;
      r_we   <= 1'b1;
    end else if (w_pop) begin
      r_rd   <= r_fifo_rd[r_rd_ptr];
      r_data <= r_fifo_data[r_rd_ptr];
      r_we   <= 1'b1;
    end else if (w_bypass) begin
      r_rd   <= wb.aluRd;
      r_data <= wb.aluData;
      r_we   <= 1'b1;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // Scoreboard: a new issue to the same register outranks the write that
  // is completing, since that issue's own write is still outstanding.
  assign w_busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign w_busy_next[gi] =
      (wb.issueValid && (wb.issueRd == 5'(gi))) ? 1'b1 :
      (r_we && (r_rd == 5'(gi)))                ? 1'b0 :
                                                  r_busy[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end
endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if #(.XLEN(XLEN)) wb_if ();

  writeback_unit #(.XLEN(XLEN), .ALU_FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_if)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_we;
  logic [31:0] m_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int alu_order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd = 5'd0; m_data = 32'd0; m_we = 1'b0; m_busy = 32'd0;
  endtask

  task automatic idle_inputs();
    wb_if.aluValid = 1'b0; wb_if.aluRd = 5'd0; wb_if.aluData = 32'd0;
    wb_if.memValid = 1'b0; wb_if.memRd = 5'd0; wb_if.memData = 32'd0;
    wb_if.issueValid = 1'b0; wb_if.issueRd = 5'd0;
  endtask

  // One clock: check ready, advance model, clock, check registered outputs.
  task automatic step();
    logic        exp_ready;
    logic        bypassed;
    logic [31:0] nb;
    ent_t        e;
    exp_ready = (m_q.size() < DEPTH);
    chk("aluReady", 32'(wb_if.aluReady), 32'(exp_ready));
    nb = m_busy;
    if (m_we) nb[m_rd] = 1'b0;
    if (wb_if.issueValid && wb_if.issueRd != 0) nb[wb_if.issueRd] = 1'b1;
    bypassed = 1'b0;
    if (wb_if.memValid && wb_if.memRd != 0) begin
      m_we = 1'b1; m_rd = wb_if.memRd; m_data = wb_if.memData;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.data;
    end else if (wb_if.aluValid && wb_if.aluRd != 0) begin
      m_we = 1'b1; m_rd = wb_if.aluRd; m_data = wb_if.aluData;
      bypassed = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (wb_if.aluValid && exp_ready && wb_if.aluRd != 0 && !bypassed)
      m_q.push_back('{rd: wb_if.aluRd, data: wb_if.aluData});
    m_busy = nb;
    @(posedge clk);
    #1;
    chk("writeEnable", 32'(wb_if.writeEnable), 32'(m_we));
    chk("rd", 32'(wb_if.rd), 32'(m_rd));
    chk("data", wb_if.data, m_data);
    chk("busyMask", wb_if.busyMask, m_busy);
    $display("cycle t=%0t we=%0d rd=%0d data=0x%08h busy=0x%08h", $time,
             wb_if.writeEnable, wb_if.rd, wb_if.data, wb_if.busyMask);
  endtask

  task automatic rand_inputs();
    wb_if.aluValid   = ($urandom_range(0, 1) == 1);
    wb_if.aluRd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    wb_if.aluData    = $urandom;
    wb_if.memValid   = ($urandom_range(0, 9) < 3);
    wb_if.memRd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    wb_if.memData    = $urandom;
    wb_if.issueValid = ($urandom_range(0, 2) == 0);
    wb_if.issueRd    = 5'($urandom_range(0, 31));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_we"}, 32'(wb_if.writeEnable), 32'd0);
    chk({tag, "_busy"}, wb_if.busyMask, 32'd0);
    chk({tag, "_ready"}, 32'(wb_if.aluReady), 32'd1);
    chk({tag, "_rd"}, 32'(wb_if.rd), 32'd0);
    chk({tag, "_data"}, wb_if.data, 32'd0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    reset_check("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step();

    // Uncontested ALU write and scoreboard clear
    wb_if.issueValid = 1'b1; wb_if.issueRd = 5'd5;
    step();
    idle_inputs();
    chk("t2_busy5_set", 32'(wb_if.busyMask[5]), 32'd1);
    wb_if.aluValid = 1'b1; wb_if.aluRd = 5'd5; wb_if.aluData = 32'h1234;
    step();
    idle_inputs();
    chk("t2_rd", 32'(wb_if.rd), 32'd5);
    chk("t2_data", wb_if.data, 32'h1234);
    chk("t2_we", 32'(wb_if.writeEnable), 32'd1);
    step();
    chk("t2_busy5_clr", 32'(wb_if.busyMask[5]), 32'd0);

    // Load preempts ALU
    wb_if.memValid = 1'b1; wb_if.memRd = 5'd7; wb_if.memData = 32'hAAAA;
    wb_if.aluValid = 1'b1; wb_if.aluRd = 5'd8; wb_if.aluData = 32'h5555;
    step();
    idle_inputs();
    chk("t3_first_rd", 32'(wb_if.rd), 32'd7);
    chk("t3_first_data", wb_if.data, 32'hAAAA);
    step();
    chk("t3_second_rd", 32'(wb_if.rd), 32'd8);
    chk("t3_second_data", wb_if.data, 32'h5555);
    chk("t3_second_we", 32'(wb_if.writeEnable), 32'd1);
    step();

    // Loads held 4 cycles while ALU offers x1..x4: FIFO fills, then drains in order
    begin
      int idx = 1;
      alu_order.delete();
      for (int c = 0; c < 12; c++) begin
        logic acc;
        wb_if.memValid = (c < 4);
        wb_if.memRd    = 5'(16 + c);
        wb_if.memData  = 32'hC000 + 32'(c);
        wb_if.aluValid = (idx <= 4);
        wb_if.aluRd    = 5'(idx);
        wb_if.aluData  = 32'h100 + 32'(idx);
        if (c == 2) chk("t4_ready_low", 32'(wb_if.aluReady), 32'd0);
        acc = wb_if.aluValid && (m_q.size() < DEPTH);
        step();
        if (acc) idx++;
        if (wb_if.writeEnable && wb_if.rd >= 1 && wb_if.rd <= 4) alu_order.push_back(int'(wb_if.rd));
      end
      idle_inputs();
      chk("t4_count", 32'(alu_order.size()), 32'd4);
      for (int k = 0; k < alu_order.size(); k++)
        chk("t4_order", 32'(alu_order[k]), 32'(k + 1));
    end
    step();

    // Result to x0 is accepted and dropped
    begin
      logic [31:0] busy_before;
      busy_before = wb_if.busyMask;
      wb_if.aluValid = 1'b1; wb_if.aluRd = 5'd0; wb_if.aluData = 32'hFFFF;
      step();
      idle_inputs();
      chk("t5_we", 32'(wb_if.writeEnable), 32'd0);
      chk("t5_busy", wb_if.busyMask, busy_before);
      chk("t5_ready", 32'(wb_if.aluReady), 32'd1);
    end

    // Issue to x9 in the cycle its earlier write commits: set wins
    wb_if.issueValid = 1'b1; wb_if.issueRd = 5'd9;
    step();
    idle_inputs();
    wb_if.aluValid = 1'b1; wb_if.aluRd = 5'd9; wb_if.aluData = 32'h99;
    step();
    idle_inputs();
    chk("t6_commit_rd", 32'(wb_if.rd), 32'd9);
    wb_if.issueValid = 1'b1; wb_if.issueRd = 5'd9;
    step();
    idle_inputs();
    chk("t6_busy9", 32'(wb_if.busyMask[9]), 32'd1);
    step();
    chk("t6_busy9_hold", 32'(wb_if.busyMask[9]), 32'd1);

    // Random traffic
    for (int c = 0; c < 200; c++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset mid-stream
    rand_inputs();
    wb_if.aluValid = 1'b1; wb_if.aluRd = 5'd3; wb_if.memValid = 1'b1; wb_if.memRd = 5'd4;
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    reset_check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    reset_check("rst_release");
    step();

    for (int c = 0; c < 200; c++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
